// File: rtl/multiword_add_seq_pkg.sv
// Shared types and defaults for the sequential multi-word adder/subtractor.
package addseq_pkg;

   typedef enum logic {S_FIRST, S_MID} addseq_state_t;

   localparam int ADDSEQ_DEFAULT_N = 8;

endpackage

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder: one full adder per bit, carry rippling LSB to MSB.
module ripple_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   logic [N:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout = w_c[N];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-word add/sub: one N-bit chunk per beat, LS chunk first, carry held across beats.
// Define OVERFLOW_DETECT_EN to add the out_ovf signed-overflow output.
//
// state   | meaning
// S_FIRST | next accepted beat starts a new operation (uses in_sub as carry-in)
// S_MID   | mid-operation; next beat uses latched sub and carry
module multiword_add_seq
   import addseq_pkg::*;
#(
   parameter int N = ADDSEQ_DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_sub,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_last,
`ifdef OVERFLOW_DETECT_EN
   output logic         out_ovf,
`endif
   output logic         out_cout
);

   addseq_state_t r_state;
   logic          r_carry_q;
   logic          r_sub_q;
   logic          r_out_valid;
   logic [N-1:0]  r_out_sum;
   logic          r_out_last;
   logic          r_out_cout;

   logic          w_first;
   logic          w_sub;
   logic          w_cin;
   logic [N-1:0]  w_b_eff;
   logic [N-1:0]  w_sum;
   logic          w_cout;
   logic          w_in_xfer;

   assign w_first   = (r_state == S_FIRST);
   assign w_sub     = w_first ? in_sub : r_sub_q;
   assign w_cin     = w_first ? in_sub : r_carry_q;
   assign w_b_eff   = in_b ^ {N{w_sub}};
   assign in_ready  = !r_out_valid || out_ready;
   assign w_in_xfer = in_valid && in_ready;

   ripple_adder #(.N(N)) u_adder (
      .i_a    (in_a),
      .i_b    (w_b_eff),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

`ifdef OVERFLOW_DETECT_EN
   logic r_out_ovf;
   logic w_ovf;

   assign w_ovf   = in_last && (in_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != in_a[N-1]);
   assign out_ovf = r_out_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_ovf <= 1'b0;
      end else if (w_in_xfer) begin
         r_out_ovf <= w_ovf;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FIRST;
         r_carry_q   <= 1'b0;
         r_sub_q     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_last  <= 1'b0;
         r_out_cout  <= 1'b0;
      end else if (w_in_xfer) begin
         r_carry_q   <= w_cout;
         if (w_first) begin
            r_sub_q <= in_sub;
         end
         r_state     <= in_last ? S_FIRST : S_MID;
         r_out_valid <= 1'b1;
         r_out_sum   <= w_sum;
         r_out_last  <= in_last;
         r_out_cout  <= w_cout & in_last;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_last  = r_out_last;
   assign out_cout  = r_out_cout;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized bench for multiword_add_seq; whole operations are modelled as wide integers.
module tb_multiword_add_seq;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         in_sub;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sum;
   logic         out_last;
   logic         out_cout;
`ifdef OVERFLOW_DETECT_EN
   logic         out_ovf;
`endif

   multiword_add_seq #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
`ifdef OVERFLOW_DETECT_EN
      .out_ovf   (out_ovf),
`endif
      .out_cout  (out_cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         sub;
      logic         last;
   } beat_t;

   typedef struct {
      logic [N-1:0] sum;
      logic         last;
      logic         cout;
      logic         ovf;
   } exp_t;

   beat_t beat_q[$];
   exp_t  exp_q[$];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Whole-operation reference: A op B as (N*beats)-bit integers, then cut into chunks.
   function automatic void add_op(input logic [127:0] a_in, input logic [127:0] b_in,
                                  input logic sub, input int beats);
      int            w;
      logic [127:0]  mask;
      logic [127:0]  a;
      logic [127:0]  b;
      logic [127:0]  res;
      logic [128:0]  wide;
      logic          cout;
      logic          ovf;
      beat_t         bt;
      exp_t          ex;
      w    = N * beats;
      mask = (128'd1 << w) - 128'd1;
      a    = a_in & mask;
      b    = b_in & mask;
      if (sub) begin
         res  = (a - b) & mask;
         cout = (a >= b);
         ovf  = (a[w-1] != b[w-1]) && (res[w-1] != a[w-1]);
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         res  = wide[127:0] & mask;
         cout = wide[w];
         ovf  = (a[w-1] == b[w-1]) && (res[w-1] != a[w-1]);
      end
      for (int i = 0; i < beats; i++) begin
         bt.a    = N'(a >> (N * i));
         bt.b    = N'(b >> (N * i));
         bt.sub  = (i == 0) ? sub : 1'($urandom_range(1));
         bt.last = (i == beats - 1);
         beat_q.push_back(bt);
         ex.sum  = N'(res >> (N * i));
         ex.last = bt.last;
         ex.cout = bt.last ? cout : 1'b0;
         ex.ovf  = bt.last ? ovf : 1'b0;
         exp_q.push_back(ex);
      end
   endfunction

   // mode 0: always ready, no gaps; 1: random ready and valid gaps; 2: stall 3 cycles then ready
   task automatic run(input int mode, input int budget);
      int cyc   = 0;
      int stall = 0;
      while ((beat_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         @(negedge clk);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(2) != 0);
            default: out_ready = (stall >= 3);
         endcase
         if (beat_q.size() > 0 && (mode != 1 || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            in_a     = beat_q[0].a;
            in_b     = beat_q[0].b;
            in_sub   = beat_q[0].sub;
            in_last  = beat_q[0].last;
         end else begin
            in_valid = 1'b0;
            in_a     = N'($urandom);
            in_b     = N'($urandom);
            in_sub   = 1'($urandom_range(1));
            in_last  = 1'($urandom_range(1));
         end
         #1;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               check("out_sum",  {{(32-N){1'b0}}, out_sum}, {{(32-N){1'b0}}, exp_q[0].sum});
               check("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
               check("out_cout", {31'd0, out_cout}, {31'd0, exp_q[0].cout});
`ifdef OVERFLOW_DETECT_EN
               check("out_ovf",  {31'd0, out_ovf}, {31'd0, exp_q[0].ovf});
`endif
               if (!out_ready) begin
                  check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                  stall++;
               end else begin
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            check("idle_in_ready", {31'd0, in_ready}, 32'd1);
         end
         if (in_valid && in_ready) void'(beat_q.pop_front());
         cyc++;
      end
      if (cyc >= budget) check("drain_timeout", beat_q.size() + exp_q.size(), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_sum"},   {{(32-N){1'b0}}, out_sum}, 32'd0);
      check({tag, "_last"},  {31'd0, out_last}, 32'd0);
      check({tag, "_cout"},  {31'd0, out_cout}, 32'd0);
`ifdef OVERFLOW_DETECT_EN
      check({tag, "_ovf"},   {31'd0, out_ovf}, 32'd0);
`endif
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #1;
      check_zero_outputs("reset");
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // directed cases
      add_op(128'h7F, 128'h01, 1'b0, 1);
      add_op(128'h00FFFF, 128'h000001, 1'b0, 3);
      add_op(128'h0100, 128'h0001, 1'b1, 2);
      run(0, 100);

      // backpressure: 3 stalled cycles on the first result
      add_op(128'h1234, 128'h0F0F, 1'b0, 2);
      add_op(128'h55, 128'hAA, 1'b1, 1);
      run(2, 100);

      // carry must not leak between back-to-back operations
      add_op(128'hFF, 128'h01, 1'b0, 1);
      add_op(128'h00, 128'h00, 1'b0, 1);
      run(0, 100);

      // reset mid-operation after a carry-producing first beat
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = 8'hFF;
      in_b      = 8'hFF;
      in_sub    = 1'b0;
      in_last   = 1'b0;
      @(negedge clk);
      in_valid  = 1'b0;
      #1;
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      check("pre_rst_sum", {{(32-N){1'b0}}, out_sum}, 32'hFE);
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midop_reset");
      @(negedge clk);
      rst_n = 1'b1;
      add_op(128'h05, 128'h03, 1'b0, 1);
      run(0, 100);

      // randomized operations
      for (int k = 0; k < 60; k++) begin
         add_op({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(1)), int'($urandom_range(1, 6)));
      end
      run(1, 5000);
      for (int k = 0; k < 30; k++) begin
         add_op({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(1)), int'($urandom_range(1, 4)));
      end
      run(0, 2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential multi-word adder/subtractor that feeds operand chunks through an N-bit ripple adder, one chunk per beat, carrying between beats. It sits directly upstream of the ripple adder and owns its carry chain across beats. Operands arrive least-significant chunk first on a valid/ready stream and leave as registered sum chunks on a matching stream. This lets a narrow adder process arbitrarily wide operands.

## Interface
- N, default 8: chunk width in bits; ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat offered.
- in_ready  output  1  block accepts the beat this cycle.
- in_a  input  N  operand A chunk.
- in_b  input  N  operand B chunk.
- in_sub  input  1  1 = A − B; sampled only on the first beat of an operation.
- in_last  input  1  marks the most-significant chunk.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result beat.
- out_sum  output  N  sum/difference chunk.
- out_last  output  1  copy of in_last for this beat.
- out_cout  output  1  final carry-out; 1 = no borrow when subtracting; 0 on non-last beats.
- out_ovf  output  1  signed overflow on last beat (only when OVERFLOW_DETECT_EN is defined).

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- States: S_FIRST (next beat starts an operation) and S_MID (mid-operation).
  - S_FIRST → S_MID on input transfer with in_last=0.
  - S_MID → S_FIRST on input transfer with in_last=1.
  - A transfer with in_last=1 in S_FIRST is a single-beat operation and stays in S_FIRST.
- Effective B is in_b ^ {N{sub}}.
  - On the first beat, sub = in_sub. sub_q latches in_sub.
  - On later beats, sub = sub_q. in_sub is ignored.
- Carry-in is sub on the first beat and carry_q on later beats.
- On every input transfer, carry_q ← adder cout.
- Output register: on input transfer, load out_sum, out_last, out_cout (cout & in_last), and out_ovf, and set out_valid.
  - If an output transfer happens with no input transfer, out_valid clears.
- in_ready = !out_valid || out_ready. No combinational path from in_valid to in_ready.
- Arithmetic is modulo 2^(N·beats). Carry wrap-around from the last beat is reported only through out_cout and is not carried into the next operation.

## Timing
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat per cycle under continuous out_ready.
- Backpressure: while out_valid && !out_ready, all out_* signals stay stable and in_ready=0.
- Reset (any time, including mid-operation): state=S_FIRST, carry_q=0, sub_q=0, out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0. Any partial operation is discarded.
- A simultaneous input and output transfer replaces the output register in the same edge, with no bubble.
- in_valid may drop between beats of one operation. State and carry_q are held until the next transfer.

## Configuration
- OVERFLOW_DETECT_EN defined: out_ovf exists.
  - On the last beat it is (a_msb == beff_msb) && (sum_msb != a_msb), where msb is the top bit of the chunk and beff is effective B.
  - It is 0 on non-last beats.
- Without the macro: the out_ovf port and its logic are absent. Everything else is identical.

## Structure
- Package addseq_pkg holds:
  - typedef enum logic {S_FIRST, S_MID} addseq_state_t;
  - localparam ADDSEQ_DEFAULT_N = 8.
- Sub-module: one instance of the team's ripple_adder #(N), driven with in_a, effective B and the selected carry-in. The carry-out and overflow registers live in this block.

## Test plan
- N=8, single beat: a=0x7F, b=0x01, sub=0, last=1 → out_sum=0x80, out_cout=0, out_ovf=1.
- 3-beat add of 0x00FFFF + 0x000001 (chunks FF/01, FF/00, 00/00) → sums 00, 00, 01; out_cout=0 on the last beat only.
- 2-beat subtract 0x0100 − 0x0001 (sub=1 on the first beat, then in_sub=1 on the second) → sums FF, 00; out_cout=1. The second-beat in_sub is ignored.
- Hold out_ready=0 for 3 cycles after the first result → in_ready=0 and out_* stable; release → next beat accepted in the same cycle, with no loss.
- Assert rst_n low after beat 1 of a 3-beat operation → all outputs 0. A following single-beat 0x05+0x03 gives 0x08, proving carry_q was cleared.
- Back-to-back operations with out_ready=1: the carry from op1's last beat (0xFF+0x01, cout=1) must not enter op2 (0x00+0x00 → 0x00).
